caesar_shift_stage: RTL and testbench

//  Consumes a plain-text letter index (0..25, A=0) from the letter counter stage.

---
 rtl/caesar_pkg.sv | 30 +++
 rtl/caesar_shift_stage_bin5_to_bcd.sv | 25 ++
 rtl/caesar_shift_stage.sv | 121 ++++++++++++
 tb/tb_caesar_shift_stage.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/caesar_pkg.sv
// Shared widths, defaults, FSM encoding and modular-reduction helper for the
// Caesar shift stage.
package caesar_pkg;

    localparam int LETTER_W           = 5;
    localparam int BCD_W              = 4;
    localparam int ALPHA_SIZE_DEFAULT = 26;
    localparam int KEY_DEFAULT        = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SHIFT   = 2'd1,
        ST_CONVERT = 2'd2,
        ST_HOLD    = 2'd3
    } state_e;

    // Repeated subtraction; 16 passes cover a 5-bit value against the smallest modulus of 2.
    function automatic logic [LETTER_W-1:0] reduceMod(input logic [LETTER_W-1:0] value,
                                                      input logic [LETTER_W:0]   modulus);
        logic [LETTER_W:0] r;
        r = {1'b0, value};
        for (int i = 0; i < 16; i++) begin
            if (r >= modulus) begin
                r = r - modulus;
            end
        end
        return r[LETTER_W-1:0];
    endfunction

endpackage

// File: rtl/caesar_shift_stage_bin5_to_bcd.sv
// Combinational 5-bit binary to two-digit BCD (tens 0..3, ones 0..9).
module bin5_to_bcd
    import caesar_pkg::*;
(
    input  logic [LETTER_W-1:0] bin_i,
    output logic [BCD_W-1:0]    tens_o,
    output logic [BCD_W-1:0]    ones_o
);

    always_comb begin
        tens_o = 4'd0;
        ones_o = 4'(bin_i);
        if (bin_i >= 5'd30) begin
            tens_o = 4'd3;
            ones_o = 4'(bin_i - 5'd30);
        end else if (bin_i >= 5'd20) begin
            tens_o = 4'd2;
            ones_o = 4'(bin_i - 5'd20);
        end else if (bin_i >= 5'd10) begin
            tens_o = 4'd1;
            ones_o = 4'(bin_i - 5'd10);
        end
    end

endmodule

// File: rtl/caesar_shift_stage.sv
// Caesar shift stage: takes a letter index over valid/ready, shifts it by the
// key (encrypt or decrypt) and presents binary plus BCD digits for the display.
module caesar_shift_stage
    import caesar_pkg::*;
#(
    parameter int ALPHA_SIZE  = ALPHA_SIZE_DEFAULT,
    parameter int DEFAULT_KEY = KEY_DEFAULT
) (
    input  logic                CLOCK_50,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [LETTER_W-1:0] in_letter,
    input  logic                key_load,
    input  logic [LETTER_W-1:0] key_in,
    input  logic                decrypt,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [LETTER_W-1:0] out_letter,
    output logic [BCD_W-1:0]    out_tens,
    output logic [BCD_W-1:0]    out_ones,
    output logic [LETTER_W-1:0] key_cur,
    output logic                err_range
);

    localparam logic [LETTER_W:0]   ALPHA6   = (LETTER_W+1)'(ALPHA_SIZE);
    localparam logic [LETTER_W-1:0] KEY_INIT = LETTER_W'(DEFAULT_KEY);

    state_e              state_q;
    logic [LETTER_W-1:0] letter_q;
    logic                decrypt_q;
    logic [LETTER_W-1:0] keyCur_q;
    logic [LETTER_W-1:0] outLetter_q;
    logic [BCD_W-1:0]    outTens_q;
    logic [BCD_W-1:0]    outOnes_q;
    logic                outValid_q;
    logic                errRange_q;

    logic [LETTER_W:0]   sum_d;
    logic [LETTER_W:0]   diff_d;
    logic [LETTER_W-1:0] shiftLetter_d;
    logic [BCD_W-1:0]    tens_d;
    logic [BCD_W-1:0]    ones_d;

    // Both operands are already below ALPHA_SIZE, so one correction step suffices.
    always_comb begin
        sum_d         = {1'b0, letter_q} + {1'b0, keyCur_q};
        diff_d        = {1'b0, letter_q} - {1'b0, keyCur_q};
        shiftLetter_d = LETTER_W'(sum_d);
        if (decrypt_q) begin
            shiftLetter_d = diff_d[LETTER_W] ? LETTER_W'(diff_d + ALPHA6) : LETTER_W'(diff_d);
        end else if (sum_d >= ALPHA6) begin
            shiftLetter_d = LETTER_W'(sum_d - ALPHA6);
        end
    end

    bin5_to_bcd u_bcd (
        .bin_i  (outLetter_q),
        .tens_o (tens_d),
        .ones_o (ones_d)
    );

    always_ff @(posedge CLOCK_50 or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            letter_q    <= '0;
            decrypt_q   <= 1'b0;
            keyCur_q    <= KEY_INIT;
            outLetter_q <= '0;
            outTens_q   <= '0;
            outOnes_q   <= '0;
            outValid_q  <= 1'b0;
            errRange_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (key_load) begin
                        keyCur_q <= reduceMod(key_in, ALPHA6);
                        if ({1'b0, key_in} >= ALPHA6) begin
                            errRange_q <= 1'b1;
                        end
                    end else if (in_valid) begin
                        letter_q  <= reduceMod(in_letter, ALPHA6);
                        decrypt_q <= decrypt;
                        state_q   <= ST_SHIFT;
                        if ({1'b0, in_letter} >= ALPHA6) begin
                            errRange_q <= 1'b1;
                        end
                    end
                end
                ST_SHIFT: begin
                    outLetter_q <= shiftLetter_d;
                    state_q     <= ST_CONVERT;
                end
                ST_CONVERT: begin
                    outTens_q  <= tens_d;
                    outOnes_q  <= ones_d;
                    outValid_q <= 1'b1;
                    state_q    <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        outValid_q <= 1'b0;
                        state_q    <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // A key strobe takes priority over a letter, so the letter is refused that cycle.
    assign in_ready   = rst && (state_q == ST_IDLE) && !key_load;
    assign out_valid  = outValid_q;
    assign out_letter = outLetter_q;
    assign out_tens   = outTens_q;
    assign out_ones   = outOnes_q;
    assign key_cur    = keyCur_q;
    assign err_range  = errRange_q;

endmodule

// File: tb/tb_caesar_shift_stage.sv
// Self-checking bench for caesar_shift_stage against a plain modular-arithmetic
// reference model (letter and key reduced with %, shift with +/- and %).
module tb_caesar_shift_stage;

    localparam int A = 26;

    logic       CLOCK_50;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] in_letter;
    logic       key_load;
    logic [4:0] key_in;
    logic       decrypt;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] out_letter;
    logic [3:0] out_tens;
    logic [3:0] out_ones;
    logic [4:0] key_cur;
    logic       err_range;

    int compared;
    int mismatched;
    int modelKey;
    bit modelErr;

    caesar_shift_stage #(
        .ALPHA_SIZE  (26),
        .DEFAULT_KEY (3)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_letter  (in_letter),
        .key_load   (key_load),
        .key_in     (key_in),
        .decrypt    (decrypt),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_letter (out_letter),
        .out_tens   (out_tens),
        .out_ones   (out_ones),
        .key_cur    (key_cur),
        .err_range  (err_range)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    function automatic int modelShift(input int l, input bit dec, input int k);
        int lr;
        lr = l % A;
        return dec ? (lr - k + A) % A : (lr + k) % A;
    endfunction

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    // Waits for in_ready, hands over one letter, and returns edges from accept to out_valid (-1 on timeout).
    task automatic applyStimulus(input int l, input bit dec, output int lat);
        int w;
        w = 0;
        while (in_ready !== 1'b1 && w < 20) begin
            tick();
            w++;
        end
        in_letter = 5'(l);
        decrypt   = dec;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        if (l >= A) modelErr = 1'b1;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        if (out_valid !== 1'b1) lat = -1;
    endtask

    task automatic loadKey(input int k);
        key_in   = 5'(k);
        key_load = 1'b1;
        tick();
        key_load = 1'b0;
        modelKey = k % A;
        if (k >= A) modelErr = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) tick();
        compared++;
        if (in_ready !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_in_ready: got %0d want 0", in_ready);
        end
        compared++;
        if (out_valid !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_out_valid: got %0d want 0", out_valid);
        end
        compared++;
        if (key_cur !== 5'd3 || err_range !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_key_err: got key %0d err %0d want key 3 err 0", key_cur, err_range);
        end
        compared++;
        if ({out_letter, out_tens, out_ones} !== 13'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_outputs: got %0d/%0d/%0d want 0/0/0", out_letter, out_tens, out_ones);
        end
        rst = 1'b1;
        modelKey = 3;
        modelErr = 1'b0;
        tick();
        compared++;
        if (in_ready !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL reset_release_ready: got %0d want 1", in_ready);
        end
    endtask

    task automatic releaseOutput(input string name);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        compared++;
        if (out_valid !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL %s_valid_drop: got %0d want 0", name, out_valid);
        end
    endtask

    task automatic test_encrypt_wrap();
        int lat;
        applyStimulus(23, 1'b0, lat);
        compared++;
        if (lat !== 2) begin
            mismatched++;
            $display("[TB] FAIL enc_wrap_latency: got %0d want 2", lat);
        end
        compared++;
        if ({out_letter, out_tens, out_ones} !== {5'd0, 4'd0, 4'd0}) begin
            mismatched++;
            $display("[TB] FAIL enc_wrap_value: got %0d/%0d/%0d want 0/0/0", out_letter, out_tens, out_ones);
        end
        releaseOutput("enc_wrap");
    endtask

    task automatic test_decrypt_wrap();
        int lat;
        applyStimulus(1, 1'b1, lat);
        compared++;
        if (lat !== 2) begin
            mismatched++;
            $display("[TB] FAIL dec_wrap_latency: got %0d want 2", lat);
        end
        compared++;
        if ({out_letter, out_tens, out_ones} !== {5'd24, 4'd2, 4'd4}) begin
            mismatched++;
            $display("[TB] FAIL dec_wrap_value: got %0d/%0d/%0d want 24/2/4", out_letter, out_tens, out_ones);
        end
        releaseOutput("dec_wrap");
    endtask

    task automatic test_backpressure();
        int lat, l, e;
        bit dec;
        l   = int'($urandom_range(0, 25));
        dec = 1'($urandom_range(0, 1));
        e   = modelShift(l, dec, modelKey);
        applyStimulus(l, dec, lat);
        for (int c = 0; c < 10; c++) begin
            compared++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_letter !== 5'(e)
                || out_tens !== 4'(e / 10) || out_ones !== 4'(e % 10)) begin
                mismatched++;
                $display("[TB] FAIL backpressure_hold c%0d: got v%0d r%0d %0d/%0d/%0d want v1 r0 %0d/%0d/%0d",
                         c, out_valid, in_ready, out_letter, out_tens, out_ones, e, e / 10, e % 10);
            end
            tick();
        end
        releaseOutput("backpressure");
        compared++;
        if (in_ready !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL backpressure_ready_return: got %0d want 1", in_ready);
        end
    endtask

    task automatic test_random();
        int lat, l, k, e;
        bit dec;
        for (int i = 0; i < 20; i++) begin
            k = int'($urandom_range(0, 31));
            loadKey(k);
            l   = int'($urandom_range(0, 31));
            dec = 1'($urandom_range(0, 1));
            e   = modelShift(l, dec, modelKey);
            applyStimulus(l, dec, lat);
            compared++;
            if (lat !== 2 || out_letter !== 5'(e) || out_tens !== 4'(e / 10) || out_ones !== 4'(e % 10)
                || key_cur !== 5'(modelKey) || err_range !== modelErr) begin
                mismatched++;
                $display("[TB] FAIL random_%0d (l%0d k%0d d%0d): got lat%0d %0d/%0d/%0d key%0d err%0d want lat2 %0d/%0d/%0d key%0d err%0d",
                         i, l, k, dec, lat, out_letter, out_tens, out_ones, key_cur, err_range,
                         e, e / 10, e % 10, modelKey, modelErr);
            end
            releaseOutput("random");
        end
    endtask

    task automatic test_key_load();
        int lat;
        rst = 1'b0;
        #2;
        rst = 1'b1;
        modelKey = 3;
        modelErr = 1'b0;
        tick();
        key_in    = 5'd29;
        key_load  = 1'b1;
        in_letter = 5'd5;
        in_valid  = 1'b1;
        #1;
        compared++;
        if (in_ready !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL keyload_in_ready: got %0d want 0", in_ready);
        end
        tick();
        key_load = 1'b0;
        in_valid = 1'b0;
        compared++;
        if (key_cur !== 5'd3 || err_range !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL keyload_reduce: got key %0d err %0d want key 3 err 1", key_cur, err_range);
        end
        modelErr = 1'b1;
        repeat (4) tick();
        compared++;
        if (out_valid !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL keyload_letter_not_taken: got out_valid %0d want 0", out_valid);
        end
        applyStimulus(10, 1'b0, lat);
        compared++;
        if (lat !== 2 || out_letter !== 5'd13 || out_tens !== 4'd1 || out_ones !== 4'd3) begin
            mismatched++;
            $display("[TB] FAIL keyload_next_letter: got lat%0d %0d/%0d/%0d want lat2 13/1/3",
                     lat, out_letter, out_tens, out_ones);
        end
        releaseOutput("keyload");
    endtask

    task automatic test_out_of_range();
        int w;
        w = 0;
        while (in_ready !== 1'b1 && w < 20) begin
            tick();
            w++;
        end
        in_letter = 5'd27;
        decrypt   = 1'b0;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        key_in   = 5'd7;
        key_load = 1'b1;
        tick();
        key_load = 1'b0;
        tick();
        compared++;
        if (out_valid !== 1'b1 || out_letter !== 5'd4 || out_tens !== 4'd0 || out_ones !== 4'd4) begin
            mismatched++;
            $display("[TB] FAIL oor_letter: got v%0d %0d/%0d/%0d want v1 4/0/4", out_valid, out_letter, out_tens, out_ones);
        end
        compared++;
        if (key_cur !== 5'd3 || err_range !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL oor_key_ignored: got key %0d err %0d want key 3 err 1", key_cur, err_range);
        end
        releaseOutput("oor");
    endtask

    task automatic test_mid_hold_reset();
        int lat;
        loadKey(5);
        applyStimulus(10, 1'b0, lat);
        compared++;
        if (out_valid !== 1'b1 || out_letter !== 5'd15) begin
            mismatched++;
            $display("[TB] FAIL midreset_setup: got v%0d letter %0d want v1 letter 15", out_valid, out_letter);
        end
        #2;
        rst = 1'b0;
        #1;
        compared++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || key_cur !== 5'd3 || err_range !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL midreset_state: got v%0d r%0d key%0d err%0d want v0 r0 key3 err0",
                     out_valid, in_ready, key_cur, err_range);
        end
        compared++;
        if ({out_letter, out_tens, out_ones} !== 13'd0) begin
            mismatched++;
            $display("[TB] FAIL midreset_outputs: got %0d/%0d/%0d want 0/0/0", out_letter, out_tens, out_ones);
        end
        #2;
        rst = 1'b1;
        modelKey = 3;
        modelErr = 1'b0;
        tick();
        compared++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL midreset_idle: got r%0d v%0d want r1 v0", in_ready, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        int letters[4];
        bit decs[4];
        int expect_q[$];
        int acceptCyc[4];
        int idx, got, cyc;
        bit acc;
        for (int i = 0; i < 4; i++) begin
            letters[i] = int'($urandom_range(0, 25));
            decs[i]    = 1'($urandom_range(0, 1));
            expect_q.push_back(modelShift(letters[i], decs[i], modelKey));
        end
        out_ready = 1'b1;
        idx = 0;
        got = 0;
        cyc = 0;
        in_letter = 5'(letters[0]);
        decrypt   = decs[0];
        in_valid  = 1'b1;
        for (int c = 0; c < 60 && got < 4; c++) begin
            acc = (in_ready === 1'b1) && in_valid;
            tick();
            cyc++;
            if (acc) begin
                acceptCyc[idx] = cyc;
                idx++;
                if (idx < 4) begin
                    in_letter = 5'(letters[idx]);
                    decrypt   = decs[idx];
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (out_valid === 1'b1 && got < 4) begin
                compared++;
                if (out_letter !== 5'(expect_q[got])) begin
                    mismatched++;
                    $display("[TB] FAIL b2b_letter_%0d: got %0d want %0d", got, out_letter, expect_q[got]);
                end
                got++;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        compared++;
        if (got !== 4 || idx !== 4) begin
            mismatched++;
            $display("[TB] FAIL b2b_count: got %0d outputs %0d accepts want 4 and 4", got, idx);
        end else begin
            for (int i = 1; i < 4; i++) begin
                compared++;
                if (acceptCyc[i] - acceptCyc[i-1] !== 4) begin
                    mismatched++;
                    $display("[TB] FAIL b2b_spacing_%0d: got %0d want 4", i, acceptCyc[i] - acceptCyc[i-1]);
                end
            end
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        modelKey   = 3;
        modelErr   = 1'b0;
        in_valid   = 1'b0;
        in_letter  = '0;
        key_load   = 1'b0;
        key_in     = '0;
        decrypt    = 1'b0;
        out_ready  = 1'b0;
        test_reset();
        test_encrypt_wrap();
        test_decrypt_wrap();
        test_backpressure();
        test_random();
        test_key_load();
        test_out_of_range();
        test_mid_hold_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
